aes_byte_scanner: RTL and testbench

Downstream display stage for the AES datapath. It captures a 128-bit cipher or decipher result and steps through its 16 bytes, one at a time. For each byte it runs a sequential binary-to-BCD conversion (double-dabble) and drives three 7-segment digits showing the value in decimal. Steps are triggered by a pulse input or by an internal auto-advance timer.

---
 rtl/aes_byte_scanner.sv | 146 ++++++++++++++
 tb/tb_aes_byte_scanner.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_byte_scanner.sv
// Byte-by-byte decimal display of a captured 128-bit AES block: each selected
// byte is converted to BCD with a sequential double-dabble and shown on three 7-segment digits.
module aes_byte_scanner #(
    parameter int TICK_DIV = 50_000_000,
    parameter int AUTO     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [127:0] block_in,
    input  logic         step,
    output logic [3:0]   byte_idx,
    output logic [7:0]   byte_val,
    output logic [6:0]   seg_1,
    output logic [6:0]   seg_2,
    output logic [6:0]   seg_3,
    output logic         busy,
    output logic         valid
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);

    typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;

    state_t           state_reg, state_next;
    logic [127:0]     blk_reg;
    logic [3:0]       idx_reg;
    logic [7:0]       val_reg;
    logic [19:0]      sr_reg;
    logic [3:0]       cnt_reg;
    logic [TW-1:0]    tick_reg;
    logic [2:0][6:0]  seg_reg;

    logic [7:0]       blk_bytes [16];
    logic [3:0]       idx_inc;
    logic             advance;
    logic             conv_done;
    logic [11:0]      bcd_adj;
    logic [19:0]      sr_shift;
    logic [2:0][6:0]  seg_dec;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_bytes
            assign blk_bytes[gi] = blk_reg[127-8*gi -: 8];
        end
        // Digit gi: 0 = ones, 1 = tens, 2 = hundreds (BCD field above the 8 binary bits).
        for (gi = 0; gi < 3; gi++) begin : g_digit
            assign bcd_adj[4*gi +: 4] = (sr_reg[8+4*gi +: 4] >= 4'd5) ?
                                        sr_reg[8+4*gi +: 4] + 4'd3 : sr_reg[8+4*gi +: 4];
            assign seg_dec[gi] = seg7(sr_reg[8+4*gi +: 4]);
        end
    endgenerate

    assign idx_inc   = idx_reg + 4'd1;
    assign conv_done = (cnt_reg == 4'd8);
    assign sr_shift  = {bcd_adj[10:0], sr_reg[7:0], 1'b0};
    // A step and a timer tick in the same cycle collapse into one advance.
    assign advance   = (state_reg == SHOW) &&
                       (step || ((AUTO != 0) && (tick_reg == TICK_LAST)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (load) begin
            state_next = CONV;
        end else begin
            case (state_reg)
                IDLE:    state_next = IDLE;
                CONV:    if (conv_done) state_next = SHOW;
                SHOW:    if (advance) state_next = CONV;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy  = (state_reg == CONV);
        valid = (state_reg == SHOW);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blk_reg  <= '0;
            idx_reg  <= '0;
            val_reg  <= '0;
            sr_reg   <= '0;
            cnt_reg  <= '0;
            tick_reg <= '0;
            seg_reg  <= {3{7'h7F}};
        end else if (load) begin
            blk_reg <= block_in;
            idx_reg <= '0;
            val_reg <= block_in[127:120];
            sr_reg  <= {12'h000, block_in[127:120]};
            cnt_reg <= '0;
        end else if (advance) begin
            idx_reg <= idx_inc;
            val_reg <= blk_bytes[idx_inc];
            sr_reg  <= {12'h000, blk_bytes[idx_inc]};
            cnt_reg <= '0;
        end else if (state_reg == CONV) begin
            if (!conv_done) begin
                sr_reg  <= sr_shift;
                cnt_reg <= cnt_reg + 4'd1;
            end else begin
                seg_reg  <= seg_dec;
                tick_reg <= '0;
            end
        end else if (state_reg == SHOW) begin
            tick_reg <= tick_reg + TICK_ONE;
        end
    end

    assign byte_idx = idx_reg;
    assign byte_val = val_reg;
    assign seg_1    = seg_reg[2];
    assign seg_2    = seg_reg[1];
    assign seg_3    = seg_reg[0];

endmodule

// File: tb/tb_aes_byte_scanner.sv
// Scoreboard bench for aes_byte_scanner: the driver predicts each displayed byte
// and its due cycle from a block/index model; a monitor checks every rising valid.
module tb_aes_byte_scanner;

    localparam int TD = 8;
    localparam logic [127:0] SPEC_BLK = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load = 1'b0;
    logic         step = 1'b0;
    logic [127:0] block_in = '0;
    logic [3:0]   byte_idx;
    logic [7:0]   byte_val;
    logic [6:0]   seg_1, seg_2, seg_3;
    logic         busy, valid;

    aes_byte_scanner #(.TICK_DIV(TD), .AUTO(1)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .block_in(block_in), .step(step),
        .byte_idx(byte_idx), .byte_val(byte_val),
        .seg_1(seg_1), .seg_2(seg_2), .seg_3(seg_3),
        .busy(busy), .valid(valid)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  idx;
        logic [7:0]  val;
        logic [20:0] segs;
        int unsigned due;
    } exp_t;
    exp_t sb[$];

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic [127:0] m_blk  = '0;
    logic [3:0]   m_idx  = '0;
    bit           m_idle = 1'b1;
    int unsigned  m_show = 0;
    int           chk_kind = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] byte_of(logic [127:0] b, logic [3:0] k);
        logic [127:0] s;
        s = b >> (8 * (15 - int'(k)));
        return s[7:0];
    endfunction

    function automatic logic [20:0] segs_of(logic [7:0] v);
        int n;
        n = int'(v);
        return {seg_tab[n / 100], seg_tab[(n / 10) % 10], seg_tab[n % 10]};
    endfunction

    // New byte selected at edge e; its digits are due 9 edges later.
    task automatic trigger(int unsigned e);
        exp_t x;
        x.idx  = m_idx;
        x.val  = byte_of(m_blk, m_idx);
        x.segs = segs_of(x.val);
        x.due  = e + 9;
        if (!m_idle && e <= m_show && sb.size() > 0) void'(sb.pop_back());
        sb.push_back(x);
        m_show   = e + 9;
        m_idle   = 1'b0;
        chk_kind = 1;
        $display("txn cyc=%0d idx=%0d val=%02h due=%0d", e, x.idx, x.val, x.due);
    endtask

    task automatic cycle(bit ld, bit st, bit rs, logic [127:0] blk);
        int unsigned e;
        @(negedge clk);
        if (chk_kind == 1) begin
            check("busy_after_trigger", 32'(busy), 32'd1);
            check("idx_after_trigger", 32'(byte_idx), 32'(m_idx));
            check("val_after_trigger", 32'(byte_val), 32'(byte_of(m_blk, m_idx)));
        end else if (chk_kind == 2) begin
            check("reset_segs", 32'({seg_1, seg_2, seg_3}), 32'({3{7'h7F}}));
            check("reset_busy", 32'(busy), 32'd0);
            check("reset_valid", 32'(valid), 32'd0);
            check("reset_idx", 32'(byte_idx), 32'd0);
            check("reset_val", 32'(byte_val), 32'd0);
        end
        chk_kind = 0;
        rst_n    = !rs;
        load     = ld;
        step     = st;
        block_in = blk;
        e = cyc + 1;
        if (rs) begin
            m_blk = '0; m_idx = '0; m_idle = 1'b1;
            sb.delete();
            chk_kind = 2;
        end else if (ld) begin
            m_blk = blk; m_idx = '0;
            trigger(e);
        end else if (!m_idle && e > m_show && (st || e == m_show + TD)) begin
            m_idx = m_idx + 4'd1;
            trigger(e);
        end
    endtask

    task automatic idle(int n);
        repeat (n) cycle(1'b0, 1'b0, 1'b0, '0);
    endtask

    function automatic logic [127:0] rnd_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: each rising valid consumes one predicted display.
    initial begin
        logic pv;
        exp_t x;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (valid && !pv) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got valid idx=%0d, want none", byte_idx);
                end else begin
                    x = sb.pop_front();
                    check("show_idx", 32'(byte_idx), 32'(x.idx));
                    check("show_val", 32'(byte_val), 32'(x.val));
                    check("show_segs", 32'({seg_1, seg_2, seg_3}), 32'(x.segs));
                    check("show_cycle", cyc, x.due);
                end
            end
            pv = valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        repeat (3) cycle(1'b0, 1'b0, 1'b1, '0);
        idle(4);
        check("idle_valid_after_reset", 32'(valid), 32'd0);

        cycle(1'b1, 1'b0, 1'b0, SPEC_BLK);
        for (int k = 0; k < 16; k++) begin
            idle(10);
            cycle(1'b0, 1'b1, 1'b0, '0);
        end
        // Step during conversion must be dropped; then let the timer advance.
        idle(3);
        cycle(1'b0, 1'b1, 1'b0, '0);
        idle(30);

        cycle(1'b1, 1'b0, 1'b0, rnd_blk());
        idle(3);
        cycle(1'b1, 1'b0, 1'b0, {8'hc8, 120'(rnd_blk())});
        idle(12);

        cycle(1'b1, 1'b0, 1'b0, rnd_blk());
        idle(4);
        cycle(1'b0, 1'b0, 1'b1, '0);
        repeat (5) cycle(1'b0, 1'b1, 1'b0, '0);
        idle(20);
        check("idle_valid", 32'(valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_idx", 32'(byte_idx), 32'd0);
        check("idle_segs", 32'({seg_1, seg_2, seg_3}), 32'({3{7'h7F}}));

        cycle(1'b1, 1'b0, 1'b0, rnd_blk());
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2)       cycle(1'b0, 1'b0, 1'b1, '0);
            else if (r < 6)  cycle(1'b1, 1'b0, 1'b0, rnd_blk());
            else if (r < 20) cycle(1'b0, 1'b1, 1'b0, '0);
            else             idle(1);
            if (r < 4) cycle(1'b1, 1'b0, 1'b0, rnd_blk());
        end

        for (int i = 0; i < 40 && sb.size() != 0; i++) idle(1);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
